branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with an n-bit saturating-counter direction predictor per entry.
- Sits beside the PC/instruction-memory fetch stage of the 5-stage pipeline. It replaces the current "predict not-taken, resolve in ID, flush IF/ID" scheme with a fetch-time prediction.
- ID-stage branch/jump resolution trains it through an update port.
- Two saturating statistics counters (resolved branches, mispredicts) support performance checks.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- ADDR_W, 32, PC/target width.
- TAG_W, 8, tag bits stored per entry.
- CNT_W, 2, direction counter width, minimum 1.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- pc_i  in  ADDR_W  fetch PC to predict.
- hit_o  out  1  valid entry whose tag matches pc_i.
- predict_taken_o  out  1  hit_o and counter MSB set.
- predict_target_o  out  ADDR_W  predicted target; equals pc_i+4 when predict_taken_o=0.
- upd_valid_i  in  1  resolved control-flow instruction present this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved instruction.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction made at fetch, carried down the pipe.
- upd_pred_target_i  in  ADDR_W  target predicted at fetch.
- bp_clr_i  in  1  invalidate all entries.
- stat_clr_i  in  1  zero both statistics counters.
- mispredict_o  out  1  combinational; asserted for the current update when it is a mispredict.
- branch_cnt_o  out  STAT_W  resolved-update count.
- mispredict_cnt_o  out  STAT_W  mispredict count.

Behaviour:
- Indexing:
  - IDX_W = log2(ENTRIES).
  - index = pc[2 +: IDX_W].
  - tag = pc[2+IDX_W +: TAG_W].
  - pc[1:0] is ignored.
- Entry state:
  - valid (1 bit), tag (TAG_W), target[ADDR_W-1:2] (stored word-aligned, bits [1:0] reconstructed as 0), counter (CNT_W).
- Lookup:
  - Purely combinational from the registered table, so zero-cycle latency.
  - No write-to-read bypass: an update in cycle N is visible to lookups from cycle N+1.
- Update (upd_valid_i=1, on the clock edge), when the entry hits:
  - Counter increments (saturates at all-ones) if taken, decrements (saturates at 0) if not taken.
  - Target is overwritten with upd_target_i only when taken.
- Update when the entry misses:
  - Taken: allocate/replace the entry with valid=1, new tag, target, counter = weakly taken (MSB=1, rest 0; 2'b10 for CNT_W=2).
  - Not taken: no allocation; the table is unchanged.
- Mispredict:
  - mispredict_o = upd_valid_i & ((upd_pred_taken_i != upd_taken_i) | (upd_taken_i & upd_pred_taken_i & upd_pred_target_i != upd_target_i)).
  - It is 0 whenever upd_valid_i=0.
- Statistics:
  - branch_cnt_o increments on every upd_valid_i.
  - mispredict_cnt_o increments when mispredict_o=1.
  - Both saturate at all-ones and never wrap.
  - stat_clr_i zeroes both counters next cycle and overrides a simultaneous increment.
- Reset (rst_i=0 at the edge):
  - All valid bits cleared; all counters set to weakly not-taken (MSB=0, rest 1; 2'b01).
  - Targets and tags need not be reset.
  - branch_cnt_o and mispredict_cnt_o set to 0.
  - Consequence: after reset hit_o=0, predict_taken_o=0, predict_target_o=pc_i+4.
  - Reset overrides every other input, including a simultaneous update.
- Clear (bp_clr_i=1): all valid bits are cleared in one cycle.
  - Counters and statistics are untouched.
  - bp_clr_i overrides a simultaneous upd_valid_i table write.
  - The statistics still count that update.
- Aliasing: two PCs with equal index and tag share an entry; this is accepted, not detected.
- Same-index replacement: an update replacing a valid entry with a different tag is silent.
- Arithmetic: pc_i+4 wraps modulo 2^ADDR_W.

Decomposition:
- Package bp_pkg holds:
  - function clog2;
  - CNT_WEAK_T / CNT_WEAK_NT encodings as functions of CNT_W;
  - function sat_update(cnt, taken, CNT_W);
  - the entry struct typedef (valid, tag, target, cnt).
- One sub-module: bp_stat_counter (STAT_W saturating counter with synchronous active-low reset, clear and increment enable). It is instantiated twice.

Test Plan:
- Reset, then pc_i=0x00000040 -> hit_o=0, predict_taken_o=0, predict_target_o=0x00000044; both counters 0.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict_o=1. Next cycle pc_i=0x40 gives hit_o=1, predict_taken_o=1, target 0x100; branch_cnt=1, mispredict_cnt=1.
- Two not-taken updates at pc=0x40 (counter 10->01->00), then a third -> counter stays 00; predict_taken_o=0, hit_o=1. One taken update then gives counter 01, predict_taken_o still 0.
- Alias test: entry at 0x40, then taken update at 0x440 (same index 0, tag 0x11) -> pc_i=0x40 misses, pc_i=0x440 hits. Not-taken update at unallocated 0x80 -> no hit at 0x80.
- Same-cycle update at 0x40 with lookup at 0x40 -> old contents presented that cycle, new contents next cycle. bp_clr_i with upd_valid_i -> table empty afterwards, branch_cnt still incremented.
- STAT_W=4 instance: 20 mispredicting updates -> both counters hold 15. stat_clr_i asserted with an update -> both read 0. rst_i=0 mid-sequence -> all hits lost.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: entry layout, counter
// encodings and the saturating direction-counter update.
package bp_pkg;

    // Entry fields are sized for the widest supported configuration; the
    // predictor zero-extends narrower fields, so unused upper bits stay constant.
    localparam int BP_TAG_MAX  = 32;
    localparam int BP_WORD_MAX = 62;
    localparam int BP_CNT_MAX  = 8;

    typedef logic [BP_TAG_MAX-1:0]  bp_tag_t;
    typedef logic [BP_WORD_MAX-1:0] bp_word_t;
    typedef logic [BP_CNT_MAX-1:0]  bp_cnt_t;

    typedef struct packed {
        logic     valid;
        bp_tag_t  tag;
        bp_word_t target;   // word address: target bits [ADDR_W-1:2]
        bp_cnt_t  cnt;
    } bp_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bp_cnt_t cnt_weak_t(input int w);
        return bp_cnt_t'(1) << (w - 1);
    endfunction

    function automatic bp_cnt_t cnt_weak_nt(input int w);
        return (bp_cnt_t'(1) << (w - 1)) - bp_cnt_t'(1);
    endfunction

    function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken, input int w);
        bp_cnt_t max_val;
        max_val = (bp_cnt_t'(1) << w) - bp_cnt_t'(1);
        if (taken) return (cnt == max_val) ? cnt : cnt + bp_cnt_t'(1);
        else       return (cnt == '0)      ? cnt : cnt - bp_cnt_t'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, ID-stage training and statistics signals of the predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              hit_o;
    logic              predict_taken_o;
    logic [ADDR_W-1:0] predict_target_o;

    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_pred_taken_i;
    logic [ADDR_W-1:0] upd_pred_target_i;

    logic              bp_clr_i;
    logic              stat_clr_i;
    logic              mispredict_o;
    logic [STAT_W-1:0] branch_cnt_o;
    logic [STAT_W-1:0] mispredict_cnt_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i, bp_clr_i, stat_clr_i,
        input  hit_o, predict_taken_o, predict_target_o, mispredict_o,
               branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i, bp_clr_i, stat_clr_i,
        output hit_o, predict_taken_o, predict_target_o, mispredict_o,
               branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/bp_stat_counter.sv
// Saturating event counter with synchronous active-low reset and clear.
module bp_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i)                     cnt_reg <= '0;
        else if (clr_i)                 cnt_reg <= '0;
        else if (inc_i && cnt_reg != '1) cnt_reg <= cnt_reg + W'(1);
    end

    assign cnt_o = cnt_reg;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; zero-cycle
// lookup from registered state, trained by resolved branches from ID.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = clog2(ENTRIES);

    bp_entry_t table_q [ENTRIES];

    // Fetch-side lookup
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    bp_entry_t        lk_entry;

    assign lk_idx   = bp.pc_i[2 +: IDX_W];
    assign lk_tag   = bp.pc_i[2+IDX_W +: TAG_W];
    assign lk_entry = table_q[lk_idx];

    assign bp.hit_o            = lk_entry.valid && (lk_entry.tag == bp_tag_t'(lk_tag));
    assign bp.predict_taken_o  = bp.hit_o && lk_entry.cnt[CNT_W-1];
    assign bp.predict_target_o = bp.predict_taken_o ? {lk_entry.target[ADDR_W-3:0], 2'b00}
                                                    : bp.pc_i + ADDR_W'(4);

    // Training side
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    bp_entry_t        upd_cur;
    bp_entry_t        upd_entry;
    logic             upd_hit;
    logic             upd_we;

    assign upd_idx = bp.upd_pc_i[2 +: IDX_W];
    assign upd_tag = bp.upd_pc_i[2+IDX_W +: TAG_W];
    assign upd_cur = table_q[upd_idx];
    assign upd_hit = upd_cur.valid && (upd_cur.tag == bp_tag_t'(upd_tag));

    always_comb begin
        upd_entry = upd_cur;
        upd_we    = 1'b0;
        if (bp.upd_valid_i) begin
            if (upd_hit) begin
                upd_we        = 1'b1;
                upd_entry.cnt = sat_update(upd_cur.cnt, bp.upd_taken_i, CNT_W);
                if (bp.upd_taken_i) upd_entry.target = bp_word_t'(bp.upd_target_i[ADDR_W-1:2]);
            end else if (bp.upd_taken_i) begin
                // Miss on a taken branch: allocate, silently evicting any other tag
                upd_we           = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = bp_tag_t'(upd_tag);
                upd_entry.target = bp_word_t'(bp.upd_target_i[ADDR_W-1:2]);
                upd_entry.cnt    = cnt_weak_t(CNT_W);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            bp_entry_t entry_reg;

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    entry_reg.valid <= 1'b0;
                    entry_reg.cnt   <= cnt_weak_nt(CNT_W);
                end else if (bp.bp_clr_i) begin
                    entry_reg.valid <= 1'b0;
                end else if (upd_we && upd_idx == IDX_W'(gi)) begin
                    entry_reg <= upd_entry;
                end
            end

            assign table_q[gi] = entry_reg;
        end
    endgenerate

    // Mispredict classification and statistics
    logic mispredict;

    assign mispredict = bp.upd_valid_i &&
                        ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                         (bp.upd_taken_i && bp.upd_pred_taken_i &&
                          (bp.upd_pred_target_i != bp.upd_target_i)));
    assign bp.mispredict_o = mispredict;

    bp_stat_counter #(.W(STAT_W)) u_branch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bp.stat_clr_i),
        .inc_i (bp.upd_valid_i),
        .cnt_o (bp.branch_cnt_o)
    );

    bp_stat_counter #(.W(STAT_W)) u_mispredict_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bp.stat_clr_i),
        .inc_i (mispredict),
        .cnt_o (bp.mispredict_cnt_o)
    );

    // Byte-offset and above-tag PC bits play no part in indexing
    logic unused_upd_pc;
    assign unused_upd_pc = ^bp.upd_pc_i;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor (ENTRIES=16, TAG_W=8, CNT_W=2, STAT_W=4).
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    branch_predictor_if #(.ADDR_W(32), .STAT_W(4)) bp ();

    branch_predictor #(
        .ENTRIES (16),
        .ADDR_W  (32),
        .TAG_W   (8),
        .CNT_W   (2),
        .STAT_W  (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp.upd_valid_i = 1'b0;
        bp.bp_clr_i    = 1'b0;
        bp.stat_clr_i  = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        bp.upd_valid_i       = 1'b1;
        bp.upd_pc_i          = pc;
        bp.upd_taken_i       = taken;
        bp.upd_target_i      = tgt;
        bp.upd_pred_taken_i  = ptaken;
        bp.upd_pred_target_i = ptgt;
    endtask

    // One update per cycle, then return to idle
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        set_upd(pc, taken, tgt, ptaken, ptgt);
        step();
        idle();
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        bp.pc_i = pc;
        #1;
        check({tag, " hit"},    32'(bp.hit_o),           32'(hit));
        check({tag, " taken"},  32'(bp.predict_taken_o), 32'(taken));
        check({tag, " target"}, bp.predict_target_o,     tgt);
    endtask

    task automatic stats(input string tag, input int bcnt, input int mcnt);
        check({tag, " branch_cnt"},     32'(bp.branch_cnt_o),     32'(bcnt));
        check({tag, " mispredict_cnt"}, 32'(bp.mispredict_cnt_o), 32'(mcnt));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bp.pc_i      = 32'h0;
        bp.upd_pc_i  = 32'h0;
        bp.upd_taken_i = 1'b0;
        bp.upd_target_i = 32'h0;
        bp.upd_pred_taken_i = 1'b0;
        bp.upd_pred_target_i = 32'h0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        look("reset", 32'h40, 1'b0, 1'b0, 32'h44);
        stats("reset", 0, 0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // First taken update allocates weakly taken (10)
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        #1 check("alloc mispredict", 32'(bp.mispredict_o), 32'd1);
        step();
        idle();
        #1 check("idle mispredict", 32'(bp.mispredict_o), 32'd0);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        look("pc low bits", 32'h42, 1'b1, 1'b1, 32'h100);
        stats("alloc", 1, 1);

        // Not-taken training: 10 -> 01 -> 00 -> 00
        set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("nt correct mispredict", 32'(bp.mispredict_o), 32'd0);
        step();
        idle();
        look("cnt 01", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        look("cnt sat 00", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        look("cnt 00->01", 32'h40, 1'b1, 1'b0, 32'h44);
        stats("training", 5, 2);

        // Taken-taken with wrong target is a mispredict; right target is not
        set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h104);
        #1 check("wrong target mispredict", 32'(bp.mispredict_o), 32'd1);
        step();
        idle();
        look("cnt 10", 32'h40, 1'b1, 1'b1, 32'h100);
        set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        #1 check("right target mispredict", 32'(bp.mispredict_o), 32'd0);
        step();
        idle();
        stats("target", 7, 3);

        // Same index, different tag replaces the entry
        upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        look("alias old", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias new", 32'h440, 1'b1, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        look("nt no alloc", 32'h80, 1'b0, 1'b0, 32'h84);
        stats("alias", 9, 4);

        // No write-to-read bypass
        set_upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h0);
        look("same cycle old", 32'h40, 1'b0, 1'b0, 32'h44);
        step();
        idle();
        look("same cycle new", 32'h40, 1'b1, 1'b1, 32'h300);

        // Clear wins over a simultaneous table write, but the update is counted
        set_upd(32'h80, 1'b1, 32'h180, 1'b1, 32'h180);
        bp.bp_clr_i = 1'b1;
        step();
        idle();
        look("clr 0x40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("clr 0x80", 32'h80, 1'b0, 1'b0, 32'h84);
        stats("clr", 11, 5);

        // Statistics saturate at 15
        for (int i = 0; i < 20; i++) upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h180);
        stats("saturate", 15, 15);
        look("sat no alloc", 32'h80, 1'b0, 1'b0, 32'h84);

        // stat_clr overrides a simultaneous increment
        set_upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h180);
        bp.stat_clr_i = 1'b1;
        step();
        idle();
        stats("stat_clr", 0, 0);

        // Reset overrides a simultaneous update and drops all entries
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        look("pre reset", 32'h40, 1'b1, 1'b1, 32'h100);
        set_upd(32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
        rst_n = 1'b0;
        step();
        idle();
        rst_n = 1'b1;
        look("post reset 0x40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("post reset 0x80", 32'h80, 1'b0, 1'b0, 32'h84);
        stats("post reset", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
